load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit between a core request port and a single-port data memory.
// Optional build macro LSU_MISALIGN_TRAP_EN: reject misaligned half/word accesses instead of aligning them.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [1:0]  wait_cnt;

  logic        req_fire;
  logic        req_err;
  logic [1:0]  eff_lane;
  logic [3:0]  store_be;
  logic [31:0] store_dat;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign req_ready = (state == IDLE);
  assign req_fire  = req_valid && req_ready;

  // Request decode: legality, effective lane after alignment, store lanes and replicated data.
  always_comb begin
    req_err   = (req_size == 2'b11);
    eff_lane  = req_addr[1:0];
    store_be  = 4'b0000;
    store_dat = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == SZ_HALF && req_addr[0]) ||
        (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`else
    if (req_size == SZ_HALF)
      eff_lane = {req_addr[1], 1'b0};
    else if (req_size == SZ_WORD)
      eff_lane = 2'b00;
`endif
    case (req_size)
      SZ_BYTE: begin
        store_be  = 4'b0001 << eff_lane;
        store_dat = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        store_be  = 4'b0011 << {eff_lane[1], 1'b0};
        store_dat = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        store_be  = 4'b1111;
        store_dat = req_wdata;
      end
      default: begin
        store_be  = 4'b0000;
        store_dat = req_wdata;
      end
    endcase
  end

  // Load lane select and extension from the raw memory word.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = lane_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (lane_q)
      2'd0:    ld_byte = mem_dout[7:0];
      2'd1:    ld_byte = mem_dout[15:8];
      2'd2:    ld_byte = mem_dout[23:16];
      default: ld_byte = mem_dout[31:24];
    endcase
    case (size_q)
      SZ_BYTE: ld_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wait_cnt   <= 2'b00;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mem_addr   <= 32'h0;
      mem_din    <= 32'h0;
      mem_we     <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          mem_we     <= 4'b0000;
          if (req_fire) begin
            size_q <= req_size;
            uns_q  <= req_unsigned;
            lane_q <= eff_lane;
            if (req_err) begin
              // Rejected accesses never touch memory and complete on the next cycle.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we) begin
              state    <= WRITE;
              mem_addr <= {req_addr[31:2], 2'b00};
              mem_din  <= store_dat;
              mem_we   <= store_be;
            end else begin
              state    <= READ;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_we     <= 4'b0000;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        READ: begin
          state    <= WAIT;
          wait_cnt <= WAIT_INIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_ext;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          mem_we     <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors, randomized ops against a byte-level memory model, reset during WRITE.
module tb_load_store_unit;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_we;

  always #5 clk = ~clk;

  load_store_unit #(.READ_LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // Data memory with a LAT-stage read pipeline and per-lane writes.
  logic [31:0] mem [0:63];
  logic [31:0] pipe [0:LAT-1];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_val = 32'h0;
  logic [7:0]  refm [0:255];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else
      for (int l = 0; l < 4; l++)
        if (mem_we[l]) mem[mem_addr[7:2]][8*l +: 8] <= mem_din[8*l +: 8];
    pipe[0] <= mem[mem_addr[7:2]];
    for (int p = 1; p < LAT; p++) pipe[p] <= pipe[p-1];
  end
  assign mem_dout = pipe[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = a[7:2]; poke_val = v;
    for (int k = 0; k < 4; k++) refm[{a[7:2], 2'b00} + k] = v[8*k +: 8];
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Reference: what the access should do, computed from byte-addressed memory.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic err, output logic [31:0] rd, output int lat,
                       output logic [3:0] be, output logic [31:0] din, output logic [31:0] ma);
    int n, base;
    logic [31:0] v;
    err = 1'b0; rd = 32'h0; be = 4'h0; din = 32'h0; v = 32'h0;
    ma = a & 32'hFFFF_FFFC;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz != 2'd3 && (a % n) != 0) err = 1'b1;
`endif
    base = int'(a[7:0]) - int'(a % n);
    if (err) begin
      lat = 1;
    end else if (we) begin
      lat = 2;
      for (int k = 0; k < n; k++) begin
        refm[(base + k) & 255] = wd[8*k +: 8];
        be[(base + k) % 4] = 1'b1;
      end
      for (int j = 0; j < 4; j++) din[8*j +: 8] = wd[8*(j % n) +: 8];
    end else begin
      lat = LAT + 2;
      for (int k = 0; k < n; k++) v[8*k +: 8] = refm[(base + k) & 255];
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endtask

  int          obs_lat, obs_wcnt, obs_wcyc;
  logic [3:0]  obs_be;
  logic [31:0] obs_din, obs_waddr, obs_raddr, obs_rdata;
  logic        obs_err, obs_moved, obs_after_valid, obs_after_ready;

  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] first_addr;
    int guard;
    obs_lat = 0; obs_wcnt = 0; obs_wcyc = 0; obs_be = 0; obs_din = 0; obs_waddr = 0;
    obs_raddr = 0; obs_rdata = 0; obs_err = 0; obs_moved = 0; first_addr = 0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_we != 4'h0) begin
        obs_wcnt++; obs_wcyc = c; obs_be = mem_we; obs_din = mem_din; obs_waddr = mem_addr;
      end
      if (c == 1) first_addr = mem_addr;
      else if (mem_addr != first_addr) obs_moved = 1'b1;
      if (resp_valid) begin
        obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err; obs_raddr = mem_addr;
        break;
      end
    end
    @(negedge clk);
    obs_after_valid = resp_valid;
    obs_after_ready = req_ready;
  endtask

  task automatic check_obs(input string tag, input logic we, input logic err, input logic [31:0] rd,
                           input int lat, input logic [3:0] be, input logic [31:0] din,
                           input logic [31:0] ma);
    check({tag, ".latency"}, obs_lat, lat);
    check({tag, ".err"}, {31'h0, obs_err}, {31'h0, err});
    check({tag, ".rdata"}, obs_rdata, rd);
    check({tag, ".single_pulse"}, {31'h0, obs_after_valid}, 32'h0);
    check({tag, ".ready_after"}, {31'h0, obs_after_ready}, 32'h1);
    if (!err && we) begin
      check({tag, ".write_count"}, obs_wcnt, 1);
      check({tag, ".write_cycle"}, obs_wcyc, 1);
      check({tag, ".mem_we"}, {28'h0, obs_be}, {28'h0, be});
      check({tag, ".mem_din"}, obs_din, din);
      check({tag, ".mem_addr_w"}, obs_waddr, ma);
    end else begin
      check({tag, ".no_write"}, obs_wcnt, 0);
    end
    if (!err) begin
      check({tag, ".mem_addr_resp"}, obs_raddr, ma);
      check({tag, ".addr_stable"}, {31'h0, obs_moved}, 32'h0);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wdata, memword;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  be;
    logic [31:0] din, maddr;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    logic        e_err;
    logic [31:0] e_rd, e_din, e_ma;
    logic [3:0]  e_be;
    int          e_lat;

    vecs[0] = '{"sw",      1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 32'h0,        2,     4'b1111, 32'hDEADBEEF, 32'h100};
    vecs[1] = '{"sb",      1, 2'd0, 0, 32'h103, 32'h000000A5, 32'h0,        0, 32'h0,        2,     4'b1000, 32'hA5A5A5A5, 32'h100};
    vecs[2] = '{"lb",      0, 2'd0, 0, 32'h102, 32'h0,        32'h12F03456, 0, 32'hFFFFFFF0, LAT+2, 4'b0000, 32'h0,        32'h100};
    vecs[3] = '{"lbu",     0, 2'd0, 1, 32'h102, 32'h0,        32'h12F03456, 0, 32'h000000F0, LAT+2, 4'b0000, 32'h0,        32'h100};
    vecs[4] = '{"lh",      0, 2'd1, 0, 32'h102, 32'h0,        32'h8001FFFF, 0, 32'hFFFF8001, LAT+2, 4'b0000, 32'h0,        32'h100};
    vecs[5] = '{"lhu",     0, 2'd1, 1, 32'h102, 32'h0,        32'h8001FFFF, 0, 32'h00008001, LAT+2, 4'b0000, 32'h0,        32'h100};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[6] = '{"lw_mis",  0, 2'd2, 0, 32'h101, 32'h0,        32'hCAFEF00D, 1, 32'h0,        1,     4'b0000, 32'h0,        32'h100};
    vecs[8] = '{"sh_mis",  1, 2'd1, 0, 32'h107, 32'h1234ABCD, 32'h0,        1, 32'h0,        1,     4'b0000, 32'h0,        32'h104};
`else
    vecs[6] = '{"lw_mis",  0, 2'd2, 0, 32'h101, 32'h0,        32'hCAFEF00D, 0, 32'hCAFEF00D, LAT+2, 4'b0000, 32'h0,        32'h100};
    vecs[8] = '{"sh_mis",  1, 2'd1, 0, 32'h107, 32'h1234ABCD, 32'h0,        0, 32'h0,        2,     4'b1100, 32'hABCDABCD, 32'h104};
`endif
    vecs[7] = '{"size11",  1, 2'd3, 0, 32'h104, 32'h11223344, 32'h0,        1, 32'h0,        1,     4'b0000, 32'h0,        32'h104};
    vecs[9] = '{"lwu",     0, 2'd2, 1, 32'h104, 32'h0,        32'h80000000, 0, 32'h80000000, LAT+2, 4'b0000, 32'h0,        32'h104};

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int p = 0; p < LAT; p++) pipe[p] = 32'h0;
    repeat (3) @(negedge clk);
    check("reset.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset.resp_err", {31'h0, resp_err}, 32'h0);
    check("reset.resp_rdata", resp_rdata, 32'h0);
    check("reset.mem_we", {28'h0, mem_we}, 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_din", mem_din, 32'h0);
    check("reset.req_ready", {31'h0, req_ready}, 32'h1);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].we) set_word(vecs[i].addr, vecs[i].memword);
      run_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      check_obs(vecs[i].name, vecs[i].we, vecs[i].err, vecs[i].rdata, vecs[i].lat,
                vecs[i].be, vecs[i].din, vecs[i].maddr);
    end

    for (int i = 0; i < 64; i++) set_word(32'(i * 4), $urandom);
    for (int i = 0; i < 80; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, 255)) | 32'h0000_0200;
      wd  = $urandom;
      model(we, sz, uns, a, wd, e_err, e_rd, e_lat, e_be, e_din, e_ma);
      run_req(we, sz, uns, a, wd);
      check_obs($sformatf("rand%0d", i), we, e_err, e_rd, e_lat, e_be, e_din, e_ma);
    end

    // Reset asserted while the store is in its WRITE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h103; req_wdata = 32'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_write.we_in_write", {28'h0, mem_we}, 32'h8);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_write.mem_we_next", {28'h0, mem_we}, 32'h0);
    check("rst_write.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_write.mem_din", mem_din, 32'h0);
    rstn = 1'b1;
    begin
      int pulses, writes;
      pulses = 0; writes = 0;
      repeat (5) begin
        @(negedge clk);
        if (resp_valid) pulses++;
        if (mem_we != 4'h0) writes++;
      end
      check("rst_write.no_resp", pulses, 0);
      check("rst_write.no_late_write", writes, 0);
    end
    check("rst_write.ready", {31'h0, req_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
